// File: rtl/scanchain_cmd_fifo.sv
// ---------------------------------------------------------------------------
// scanchain_cmd_fifo
//
// Command buffer between the UART scan-chain client (producer) and the
// scan-chain writer (consumer). Each entry is {reset flag, address, payload}.
// The host can stream several commands back-to-back while the writer is busy
// shifting the previous one.
//
// Both sides use valid/ready handshakes. The head entry is presented from
// registered outputs, so a push into an empty FIFO appears on out_* one cycle
// later. The occupancy count includes the entry currently shown on out_*.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   flush        synchronous discard of every entry (overflow is kept)
//   in_valid     upstream command valid
//   in_ready     room for one more command (count < DEPTH)
//   in_addr      command address
//   in_payload   command payload
//   in_reset     command is a scan-chain reset
//   out_valid    head command valid toward the writer
//   out_ready    writer accepts the head
//   out_addr     head address
//   out_payload  head payload
//   out_reset    head reset flag
//   count        occupancy, 0..DEPTH
//   overflow     sticky: in_valid seen while full (cleared by reset only)
//
// Optional build macro SCANCHAIN_CMD_FIFO_STATS_EN adds:
//   cmd_total    accepted pushes, wraps at 2^16
//   high_water   largest occupancy reached
// Both statistics are cleared by reset_n only, never by flush.
// ---------------------------------------------------------------------------
module scanchain_cmd_fifo #(
    parameter  int ADDR_BITS    = 12,
    parameter  int PAYLOAD_BITS = 169,
    parameter  int DEPTH        = 4,
    localparam int CNT_BITS     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_BITS-1:0]    in_addr,
    input  logic [PAYLOAD_BITS-1:0] in_payload,
    input  logic                    in_reset,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_BITS-1:0]    out_addr,
    output logic [PAYLOAD_BITS-1:0] out_payload,
    output logic                    out_reset,
    output logic [CNT_BITS-1:0]     count,
`ifdef SCANCHAIN_CMD_FIFO_STATS_EN
    output logic [15:0]             cmd_total,
    output logic [CNT_BITS-1:0]     high_water,
`endif
    output logic                    overflow
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int ENTRY_W  = 1 + ADDR_BITS + PAYLOAD_BITS;

    logic [ENTRY_W-1:0]  mem [DEPTH];

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic [ENTRY_W-1:0]  out_entry_q, out_entry_d;
    logic                overflow_q, overflow_d;

    logic [ENTRY_W-1:0]  in_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                full;
    logic                push;
    logic                pop;

    assign in_entry = {in_reset, in_addr, in_payload};
    assign full     = (count_q == CNT_BITS'(DEPTH));
    assign in_ready = !full;

    // Flush wins over any same-cycle handshake.
    assign push = in_valid && !full && !flush;
    assign pop  = out_valid_q && out_ready && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_entry_d = out_entry_q;
        overflow_d  = overflow_q | (in_valid & full);
        head_entry  = mem[rd_ptr_q];

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // The next head lives at rd_ptr_d. If that slot is the one being
        // written this cycle (FIFO was empty or drains to empty), the memory
        // does not hold it yet, so take it straight from the input.
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_entry = in_entry;
        end else begin
            head_entry = mem[rd_ptr_d];
        end

        out_valid_d = (count_d != '0);
        // Output fields only reload when there is a head to show; while the
        // writer stalls rd_ptr is unchanged, so the same entry is reloaded.
        if (count_d != '0) begin
            out_entry_d = head_entry;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid                           = out_valid_q;
    assign {out_reset, out_addr, out_payload}  = out_entry_q;
    assign count                               = count_q;
    assign overflow                            = overflow_q;

`ifdef SCANCHAIN_CMD_FIFO_STATS_EN
    logic [15:0]         cmd_total_q, cmd_total_d;
    logic [CNT_BITS-1:0] high_water_q, high_water_d;

    always_comb begin
        cmd_total_d  = cmd_total_q;
        high_water_d = high_water_q;
        if (push) begin
            cmd_total_d = cmd_total_q + 16'd1;
        end
        if (count_d > high_water_q) begin
            high_water_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_total_q  <= '0;
            high_water_q <= '0;
        end else begin
            cmd_total_q  <= cmd_total_d;
            high_water_q <= high_water_d;
        end
    end

    assign cmd_total  = cmd_total_q;
    assign high_water = high_water_q;
`endif

endmodule

// File: tb/tb_scanchain_cmd_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for scanchain_cmd_fifo. A queue-based model holds the commands
// the FIFO should contain; the head of the queue is what out_* must show.
// ---------------------------------------------------------------------------
module tb_scanchain_cmd_fifo;

    localparam int AB = 12;
    localparam int PB = 169;
    localparam int D  = 4;
    localparam int CB = $clog2(D + 1);
    localparam int EW = 1 + AB + PB;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AB-1:0] in_addr;
    logic [PB-1:0] in_payload;
    logic          in_reset;
    logic          out_valid;
    logic          out_ready;
    logic [AB-1:0] out_addr;
    logic [PB-1:0] out_payload;
    logic          out_reset;
    logic [CB-1:0] count;
    logic          overflow;
`ifdef SCANCHAIN_CMD_FIFO_STATS_EN
    logic [15:0]   cmd_total;
    logic [CB-1:0] high_water;
`endif

    scanchain_cmd_fifo #(
        .ADDR_BITS    (AB),
        .PAYLOAD_BITS (PB),
        .DEPTH        (D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_payload  (in_payload),
        .in_reset    (in_reset),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_payload (out_payload),
        .out_reset   (out_reset),
        .count       (count),
`ifdef SCANCHAIN_CMD_FIFO_STATS_EN
        .cmd_total   (cmd_total),
        .high_water  (high_water),
`endif
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [EW-1:0] mq[$];
    logic          m_ovf   = 1'b0;
    int            m_total = 0;
    int            m_hw    = 0;

    function automatic logic [PB-1:0] rpay();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[PB-1:0];
    endfunction

    // Apply inputs for one cycle, advance the model, step past the edge.
    task automatic drive(input logic v, input logic r, input logic [AB-1:0] a,
                         input logic [PB-1:0] p, input logic rs, input logic f);
        bit do_pop;
        bit do_push;
        in_valid   = v;
        out_ready  = r;
        in_addr    = a;
        in_payload = p;
        in_reset   = rs;
        flush      = f;
        if (v && mq.size() == D) m_ovf = 1'b1;
        if (f) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && r;
            do_push = v && (mq.size() < D);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({rs, a, p});
                m_total = m_total + 1;
            end
        end
        if (mq.size() > m_hw) m_hw = mq.size();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, r, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(1'b0);
        idle(1'b0);
        n_tests++;
        if ({in_ready, out_valid, count, overflow} !== {1'b1, 1'b0, CB'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b cnt=%0d ovf=%b want 1 0 0 0",
                     in_ready, out_valid, count, overflow);
        end
        n_tests++;
        if ({out_reset, out_addr, out_payload} !== {EW{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {out_reset, out_addr, out_payload});
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(1'b0);
        n_tests++;
        if ({in_ready, out_valid, count} !== {1'b1, 1'b0, CB'(0)}) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b vld=%b cnt=%0d want 1 0 0",
                     in_ready, out_valid, count);
        end
    endtask

    task automatic test_single();
        logic [PB-1:0] p;
        p = '0;
        p[0] = 1'b1;
        p[PB-1] = 1'b1;
        drive(1'b1, 1'b1, 12'h0A5, p, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== 12'h0A5 || out_payload !== p || out_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL single_head: got vld=%b addr=%h rst=%b pay=%h want 1 0a5 0 %h",
                     out_valid, out_addr, out_reset, out_payload, p);
        end
        n_tests++;
        if (count !== CB'(1)) begin
            n_fail++;
            $display("FAIL single_count: got %0d want 1", count);
        end
        idle(1'b1);
        n_tests++;
        if (count !== CB'(0) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got cnt=%0d vld=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= D; i++) drive(1'b1, 1'b0, AB'(i), rpay(), 1'b0, 1'b0);
        n_tests++;
        if (count !== CB'(D) || in_ready !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b ovf=%b want 4 0 0", count, in_ready, overflow);
        end
        drive(1'b1, 1'b0, AB'(5), rpay(), 1'b0, 1'b0);
        n_tests++;
        if (overflow !== 1'b1 || count !== CB'(D)) begin
            n_fail++;
            $display("FAIL fill_overflow: got ovf=%b cnt=%0d want 1 4", overflow, count);
        end
        for (int i = 1; i <= D; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_addr !== AB'(i) || {out_reset, out_addr, out_payload} !== mq[0]) begin
                n_fail++;
                $display("FAIL drain_order %0d: got vld=%b addr=%0d want 1 %0d", i, out_valid, out_addr, i);
            end
            idle(1'b1);
        end
        n_tests++;
        if (count !== CB'(0) || out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_end: got cnt=%0d vld=%b ovf=%b want 0 0 1", count, out_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, AB'($urandom), rpay(), 1'($urandom), 1'b0);
        drive(1'b1, 1'b0, AB'($urandom), rpay(), 1'($urandom), 1'b0);
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || {out_reset, out_addr, out_payload} !== mq[0]) begin
                n_fail++;
                $display("FAIL b2b_head cyc %0d: got %h want %h", c, {out_reset, out_addr, out_payload}, mq[0]);
            end
            drive(1'b1, 1'b1, AB'($urandom), rpay(), 1'($urandom), 1'b0);
            n_tests++;
            if (count !== CB'(2)) begin
                n_fail++;
                $display("FAIL b2b_count cyc %0d: got %0d want 2", c, count);
            end
        end
        idle(1'b1);
        idle(1'b1);
        n_tests++;
        if (count !== CB'(0)) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d want 0", count);
        end
    endtask

    task automatic test_reset_flag();
        drive(1'b1, 1'b0, AB'($urandom), rpay(), 1'b1, 1'b0);
        drive(1'b1, 1'b0, 12'd7, rpay(), 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL rflag_first: got vld=%b rst=%b want 1 1", out_valid, out_reset);
        end
        idle(1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || out_reset !== 1'b0 || out_addr !== 12'd7) begin
            n_fail++;
            $display("FAIL rflag_second: got vld=%b rst=%b addr=%0d want 1 0 7", out_valid, out_reset, out_addr);
        end
        idle(1'b1);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, AB'($urandom), rpay(), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 12'h3C3, rpay(), 1'b0, 1'b1);
        n_tests++;
        if (count !== CB'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_now: got cnt=%0d vld=%b rdy=%b want 0 0 1", count, out_valid, in_ready);
        end
        idle(1'b1);
        n_tests++;
        if (count !== CB'(0) || out_valid !== 1'b0 || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL flush_after: got cnt=%0d vld=%b ovf=%b want 0 0 %b", count, out_valid, overflow, m_ovf);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  AB'($urandom), rpay(), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 40) == 0));
            n_tests++;
            if (count !== CB'(mq.size()) || out_valid !== (mq.size() != 0) ||
                in_ready !== (mq.size() < D) || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: got cnt=%0d vld=%b rdy=%b ovf=%b want cnt=%0d ovf=%b",
                         c, count, out_valid, in_ready, overflow, mq.size(), m_ovf);
            end
            if (mq.size() != 0) begin
                n_tests++;
                if ({out_reset, out_addr, out_payload} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_head cyc %0d: got %h want %h", c, {out_reset, out_addr, out_payload}, mq[0]);
                end
            end
        end
`ifdef SCANCHAIN_CMD_FIFO_STATS_EN
        n_tests++;
        if (cmd_total !== 16'(m_total) || high_water !== CB'(m_hw)) begin
            n_fail++;
            $display("FAIL stats: got total=%0d hw=%0d want %0d %0d", cmd_total, high_water, m_total, m_hw);
        end
`endif
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, AB'($urandom), rpay(), 1'b0, 1'b0);
        drive(1'b1, 1'b0, AB'($urandom), rpay(), 1'b0, 1'b0);
        drive(1'b1, 1'b0, AB'($urandom), rpay(), 1'b0, 1'b0);
        idle(1'b1);
        // Mid-cycle, well clear of any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_ovf   = 1'b0;
        m_total = 0;
        m_hw    = 0;
        n_tests++;
        if ({in_ready, out_valid, count, overflow} !== {1'b1, 1'b0, CB'(0), 1'b0} ||
            {out_reset, out_addr, out_payload} !== {EW{1'b0}}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b cnt=%0d ovf=%b data=%h want 1 0 0 0 0",
                     in_ready, out_valid, count, overflow, {out_reset, out_addr, out_payload});
        end
`ifdef SCANCHAIN_CMD_FIFO_STATS_EN
        n_tests++;
        if (cmd_total !== 16'd0 || high_water !== CB'(0)) begin
            n_fail++;
            $display("FAIL async_stats: got %0d %0d want 0 0", cmd_total, high_water);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        idle(1'b0);
        n_tests++;
        if (count !== CB'(0) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_release: got cnt=%0d vld=%b want 0 0", count, out_valid);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_addr    = '0;
        in_payload = '0;
        in_reset   = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_reset_flag();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
